// File: rtl/qupls4_const_line_packer_if.sv
// Handshake bundle between the code loader, the line packer and the I-store write port.
interface qupls4_const_line_packer_if #(
    parameter int LINE_BYTES = 64
);
    logic                    in_valid;
    logic                    in_ready;
    logic [47:0]             in_inst;
    logic [4:0]              in_cnst_bytes;
    logic [191:0]            in_cnst;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*LINE_BYTES-1:0] out_line;
    logic [3:0]              out_ninst;
    logic [6:0]              out_cnst_base;

    modport master (
        output in_valid, in_inst, in_cnst_bytes, in_cnst, in_last, out_ready,
        input  in_ready, out_valid, out_line, out_ninst, out_cnst_base
    );

    modport slave (
        input  in_valid, in_inst, in_cnst_bytes, in_cnst, in_last, out_ready,
        output in_ready, out_valid, out_line, out_ninst, out_cnst_base
    );
endinterface

// File: rtl/qupls4_const_line_packer.sv
// Packs 48-bit instructions from byte 0 upward and their constants from the line end downward.
// Optional line/padding statistics counters are enabled by defining QUPLS4_PACK_STATS_EN.
module qupls4_const_line_packer #(
    parameter int         LINE_BYTES = 64,
    parameter int         MAX_INST   = 10,
    parameter logic [7:0] FILL_BYTE  = 8'h00
) (
    input  logic clk,
    input  logic rst,
    qupls4_const_line_packer_if.slave bus
`ifdef QUPLS4_PACK_STATS_EN
    ,
    output logic [31:0] stat_lines,
    output logic [31:0] stat_pad_bytes
`endif
);
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [8:0] LB9        = 9'(LINE_BYTES);
    localparam logic [3:0] MAXI       = 4'(MAX_INST);
    localparam logic [6:0] BASE_EMPTY = 7'(LINE_BYTES - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [8:0]              r_ibytes;
    logic [8:0]              r_cbytes;
    logic [3:0]              r_ninst;
    logic [6:0]              r_cnst_base;
    logic [8*LINE_BYTES-1:0] r_line;
    logic [8*LINE_BYTES-1:0] w_line_next;

    logic [8:0]              w_n;
    logic [8:0]              w_ib_next;
    logic [8:0]              w_cb_next;
    logic [8:0]              w_c_lo;
    logic [3:0]              w_ninst_next;
    logic                    w_fits;
    logic                    w_accept;
    logic                    w_close;
    logic                    w_spill;
    logic                    w_out_hs;
    logic [7:0]              w_inst_b [8];
    logic [7:0]              w_cnst_b [32];

    // Odd constant counts drop bit 0; anything beyond 24 bytes is clamped.
    assign w_n          = (bus.in_cnst_bytes > 5'd24) ? 9'd24 : {4'd0, bus.in_cnst_bytes[4:1], 1'b0};
    assign w_ib_next    = r_ibytes + 9'd6;
    assign w_cb_next    = r_cbytes + w_n;
    assign w_ninst_next = r_ninst + 4'd1;
    assign w_c_lo       = LB9 - r_cbytes - w_n;
    assign w_fits       = ((r_ibytes + 9'd6 + r_cbytes + w_n) <= LB9) && (r_ninst < MAXI);
    assign w_accept     = (r_state == ST_FILL) && bus.in_valid && w_fits;
    assign w_close      = bus.in_last || (w_ninst_next == MAXI) || ((w_ib_next + w_cb_next) > (LB9 - 9'd6));
    assign w_spill      = (r_state == ST_FILL) && bus.in_valid && !w_fits && (r_ninst != 4'd0);
    assign w_out_hs     = (r_state == ST_EMIT) && bus.out_ready;

    assign bus.in_ready      = (r_state == ST_FILL);
    assign bus.out_valid     = (r_state == ST_EMIT);
    assign bus.out_line      = r_line;
    assign bus.out_ninst     = r_ninst;
    assign bus.out_cnst_base = r_cnst_base;

    // Split the incoming instruction and constant words into byte lanes.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_inst_b[i] = FILL_BYTE;
        end
        for (int i = 0; i < 6; i++) begin
            w_inst_b[i] = bus.in_inst[8*i +: 8];
        end
        for (int i = 0; i < 32; i++) begin
            w_cnst_b[i] = 8'h00;
        end
        for (int i = 0; i < 24; i++) begin
            w_cnst_b[i] = bus.in_cnst[8*i +: 8];
        end
    end

    // Line image after merging the offered instruction and its constants.
    always_comb begin
        w_line_next = r_line;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if ((9'(k) >= r_ibytes) && (9'(k) < w_ib_next)) begin
                w_line_next[8*k +: 8] = w_inst_b[3'(9'(k) - r_ibytes)];
            end else if ((9'(k) >= w_c_lo) && (9'(k) < (w_c_lo + w_n))) begin
                w_line_next[8*k +: 8] = w_cnst_b[5'(9'(k) - w_c_lo)];
            end else begin
                w_line_next[8*k +: 8] = r_line[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: close on a closing accept or when a pending instruction will not fit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_close) begin
                    w_state_next = ST_EMIT;
                end else if (w_spill) begin
                    w_state_next = ST_EMIT;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    w_state_next = ST_FILL;
                end else begin
                    w_state_next = ST_EMIT;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    // Line image and fill counters; the handshake clears the line for the next fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line      <= {LINE_BYTES{FILL_BYTE}};
            r_ibytes    <= 9'd0;
            r_cbytes    <= 9'd0;
            r_ninst     <= 4'd0;
            r_cnst_base <= BASE_EMPTY;
        end else if (w_out_hs) begin
            r_line      <= {LINE_BYTES{FILL_BYTE}};
            r_ibytes    <= 9'd0;
            r_cbytes    <= 9'd0;
            r_ninst     <= 4'd0;
            r_cnst_base <= BASE_EMPTY;
        end else if (w_accept) begin
            r_line      <= w_line_next;
            r_ibytes    <= w_ib_next;
            r_cbytes    <= w_cb_next;
            r_ninst     <= w_ninst_next;
            r_cnst_base <= (w_cb_next == 9'd0) ? BASE_EMPTY : 7'(LB9 - w_cb_next);
        end else begin
            r_line      <= r_line;
            r_ibytes    <= r_ibytes;
            r_cbytes    <= r_cbytes;
            r_ninst     <= r_ninst;
            r_cnst_base <= r_cnst_base;
        end
    end

`ifdef QUPLS4_PACK_STATS_EN
    logic [31:0] r_stat_lines;
    logic [31:0] r_stat_pad;

    assign stat_lines     = r_stat_lines;
    assign stat_pad_bytes = r_stat_pad;

    // Emitted-line and padding-byte counters, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_lines <= 32'd0;
            r_stat_pad   <= 32'd0;
        end else if (w_out_hs) begin
            r_stat_lines <= r_stat_lines + 32'd1;
            r_stat_pad   <= r_stat_pad + {23'd0, (LB9 - r_ibytes - r_cbytes)};
        end else begin
            r_stat_lines <= r_stat_lines;
            r_stat_pad   <= r_stat_pad;
        end
    end
`endif

endmodule

// File: tb/tb_qupls4_const_line_packer.sv
// Scoreboard bench: a byte-array line model queues expected lines, a monitor checks each emitted one.
module tb_qupls4_const_line_packer;
    localparam int LB   = 64;
    localparam int MAXI = 10;

    logic clk = 1'b0;
    logic rst;
    logic hold;

    qupls4_const_line_packer_if #(.LINE_BYTES(LB)) bus();

`ifdef QUPLS4_PACK_STATS_EN
    logic [31:0] stat_lines;
    logic [31:0] stat_pad_bytes;
`endif

    qupls4_const_line_packer #(
        .LINE_BYTES(LB),
        .MAX_INST(MAXI),
        .FILL_BYTE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef QUPLS4_PACK_STATS_EN
        ,
        .stat_lines(stat_lines),
        .stat_pad_bytes(stat_pad_bytes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*LB-1:0] line;
        int              ninst;
        int              base;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_line [LB];
    int         m_ib;
    int         m_cb;
    int         m_ninst;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_line(input string name, input logic [8*LB-1:0] act, input logic [8*LB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void m_clear();
        m_ib = 0;
        m_cb = 0;
        m_ninst = 0;
        for (int k = 0; k < LB; k++) m_line[k] = 8'h00;
    endfunction

    function automatic int m_n(input int nb);
        return (nb > 24) ? 24 : (nb / 2) * 2;
    endfunction

    function automatic bit m_fits(input int n);
        return ((m_ib + 6 + m_cb + n) <= LB) && (m_ninst < MAXI);
    endfunction

    function automatic void m_close();
        exp_t e;
        for (int k = 0; k < LB; k++) e.line[8*k +: 8] = m_line[k];
        e.ninst = m_ninst;
        e.base  = (m_cb == 0) ? LB - 1 : LB - m_cb;
        exp_q.push_back(e);
        m_clear();
    endfunction

    function automatic void m_place(input logic [47:0] inst, input int n, input logic [191:0] cnst, input bit last);
        for (int i = 0; i < 6; i++) m_line[m_ib + i] = inst[8*i +: 8];
        for (int i = 0; i < n; i++) m_line[LB - m_cb - n + i] = cnst[8*i +: 8];
        m_ib += 6;
        m_cb += n;
        m_ninst++;
        if (last || (m_ninst == MAXI) || (m_ib + m_cb > LB - 6)) m_close();
    endfunction

    // Offer one instruction until the packer takes it; a ready cycle that cannot fit closes the line.
    task automatic send(input logic [47:0] inst, input int nb, input logic [191:0] cnst, input bit last);
        int n;
        bit done;
        n = m_n(nb);
        done = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_inst       = inst;
        bus.in_cnst_bytes = 5'(nb);
        bus.in_cnst       = cnst;
        bus.in_last       = last;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (m_fits(n)) begin
                    m_place(inst, n, cnst, last);
                    done = 1'b1;
                end else begin
                    m_close();
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        chk("wait_out_valid", longint'(seen), 64'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(negedge clk);
        chk("drain_queue", longint'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    function automatic logic [191:0] rnd192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Consumer: random back-pressure unless the sequence is holding the line.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold) bus.out_ready = 1'b0;
            else bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every handshaken line and the EMIT-phase invariants.
    initial begin : mon
        exp_t            e;
        logic [8*LB-1:0] prev_line;
        int              prev_ninst;
        int              prev_base;
        bit              prev_hold;
        bit              hs_prev;
        prev_hold = 1'b0;
        hs_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                hs_prev   = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("ready_after_hs", longint'({bus.in_ready, bus.out_valid}), 64'h2);
                    hs_prev = 1'b0;
                end
                if (bus.out_valid) begin
                    chk("in_ready_in_emit", longint'(bus.in_ready), 64'd0);
                    if (prev_hold) begin
                        chk_line("hold_line", bus.out_line, prev_line);
                        chk("hold_meta", longint'({bus.out_ninst, bus.out_cnst_base}),
                            longint'({4'(prev_ninst), 7'(prev_base)}));
                    end
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_line actual=line required=none");
                        end else begin
                            e = exp_q.pop_front();
                            chk_line("line", bus.out_line, e.line);
                            chk("ninst", longint'(bus.out_ninst), longint'(e.ninst));
                            chk("cnst_base", longint'(bus.out_cnst_base), longint'(e.base));
                        end
                        hs_prev   = 1'b1;
                        prev_hold = 1'b0;
                    end else begin
                        prev_hold  = 1'b1;
                        prev_line  = bus.out_line;
                        prev_ninst = int'(bus.out_ninst);
                        prev_base  = int'(bus.out_cnst_base);
                    end
                end else begin
                    prev_hold = 1'b0;
                end
            end
        end
    end

    initial begin
        hold              = 1'b1;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_inst       = 48'd0;
        bus.in_cnst_bytes = 5'd0;
        bus.in_cnst       = 192'd0;
        bus.in_last       = 1'b0;
        bus.out_ready     = 1'b0;
        m_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 64'd1);
        chk("rst_out_valid", longint'(bus.out_valid), 64'd0);
        chk("rst_ninst", longint'(bus.out_ninst), 64'd0);
        chk("rst_cnst_base", longint'(bus.out_cnst_base), 64'd63);
        chk_line("rst_line", bus.out_line, '0);
`ifdef QUPLS4_PACK_STATS_EN
        chk("rst_stat_lines", longint'(stat_lines), 64'd0);
`endif
        @(posedge clk);
        #1 hold = 1'b0;

        send(48'hA1A2A3A4A5A6, 0, 192'd0, 1'b0);
        send(48'hB1B2B3B4B5B6, 0, 192'd0, 1'b0);
        send(48'hC1C2C3C4C5C6, 0, 192'd0, 1'b1);
        send(48'h112233445566, 8, 192'h0807060504030201, 1'b1);
        for (int i = 0; i < 3; i++) send(rnd48(), 24, rnd192(), i == 2);
        for (int i = 0; i < 10; i++) send(rnd48(), 0, 192'd0, 1'b0);
        wait_drain();

        // Hold the line for five cycles, then release it.
        hold = 1'b1;
        bus.out_ready = 1'b0;
        send(rnd48(), 4, rnd192(), 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_out_valid", longint'(bus.out_valid), 64'd1);
        end
        hold = 1'b0;
        wait_drain();

        // Reset while a line is waiting drops it.
        hold = 1'b1;
        bus.out_ready = 1'b0;
        send(rnd48(), 6, rnd192(), 1'b1);
        wait_valid();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_emit_out_valid", longint'(bus.out_valid), 64'd0);
        chk("rst_emit_in_ready", longint'(bus.in_ready), 64'd1);
        exp_q.delete();
        m_clear();
`ifdef QUPLS4_PACK_STATS_EN
        chk("rst2_stat_lines", longint'(stat_lines), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        hold = 1'b0;
        send(rnd48(), 0, 192'd0, 1'b1);
        wait_drain();
`ifdef QUPLS4_PACK_STATS_EN
        chk("stat_lines_one", longint'(stat_lines), 64'd1);
        chk("stat_pad_one", longint'(stat_pad_bytes), 64'd58);
`endif

        for (int i = 0; i < 80; i++) begin
            send(rnd48(), int'($urandom_range(0, 31)), rnd192(), $urandom_range(0, 7) == 0);
        end
        send(rnd48(), 2, rnd192(), 1'b1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qupls4_const_line_packer.md
Name: qupls4_const_line_packer

Overview:
Packs a stream of 48-bit instructions and their trailing constants into cache-line images for the instruction store.
- Instructions are placed from byte 0 upward.
- Constants are placed from the end of the line working backwards.
- This is the same layout the constant-aware fetch decode consumes.
- Sits between the code loader/translator and the I-cache/I-RAM write port.
- Emits one completed line at a time with a valid/ready handshake.

Parameters:
LINE_BYTES, 64, bytes per emitted cache line (power of two, 32..128).
MAX_INST, 10, maximum instruction slots per line.
FILL_BYTE, 8'h00, value written to unused bytes.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction + constants offered
in_ready  out  1  packer accepts this cycle
in_inst  in  48  instruction word
in_cnst_bytes  in  5  total constant bytes for this instruction, 0..24, even
in_cnst  in  192  constant data, little-endian, byte 0 = in_cnst[7:0]
in_last  in  1  close the line after this instruction
out_valid  out  1  completed line available
out_ready  in  1  consumer takes line
out_line  out  8*LINE_BYTES  line image, byte k = bits [8k+7:8k]
out_ninst  out  4  instructions in line
out_cnst_base  out  7  byte offset of lowest constant byte; LINE_BYTES-1 when the line has no constants

Behaviour:
Clock and reset:
- One clock, clk; rst asynchronous, active-high.
- Reset state: state=FILL, ibytes=0, cbytes=0, ninst=0, line image all FILL_BYTE, out_valid=0, out_ninst=0, out_cnst_base=LINE_BYTES-1.
- in_ready is 1 after reset.

States: FILL, EMIT.

FILL:
- in_ready=1.
- fits = (ibytes+6+cbytes+in_cnst_bytes <= LINE_BYTES) && ninst<MAX_INST.
- in_cnst_bytes bit0 is ignored (treated as 0); values >24 are clamped to 24.
- Accept on in_valid & in_ready & fits:
  - write in_inst to bytes [ibytes, ibytes+5];
  - write in_cnst bytes 0..n-1 to line bytes [LINE_BYTES-cbytes-n, LINE_BYTES-cbytes-1], with constant byte 0 at the lowest address;
  - ibytes+=6, cbytes+=n, ninst+=1.
- Close after accept (go to EMIT next cycle) if any of:
  - in_last;
  - ninst reaches MAX_INST;
  - ibytes+cbytes > LINE_BYTES-6, i.e. no room for another bare instruction.
- in_valid & !fits & ninst>0: nothing accepted, go to EMIT; the offered instruction stays pending upstream.
- !fits with ninst==0 cannot occur (max 6+24 < 32).

EMIT:
- in_ready=0, out_valid=1.
- out_line, out_ninst and out_cnst_base are stable and registered.
- out_cnst_base = cbytes==0 ? LINE_BYTES-1 : LINE_BYTES-cbytes.
- On out_valid & out_ready: out_valid=0 next cycle, image reset to FILL_BYTE, counters to 0, state FILL.
- in_ready is 1 again in the cycle after the handshake.

Latency and ordering:
- Line is visible on out_line the cycle after the closing accept (or the cycle after the !fits detect).
- An empty line is never emitted.
- in_ready is registered-state based only, with no combinational path from out_ready.
- Reset during EMIT drops the line; out_valid=0 immediately (async).

Optional Feature:
QUPLS4_PACK_STATS_EN.
- Defined: adds outputs stat_lines[31:0] and stat_pad_bytes[31:0].
  - Both are reset to 0 and wrap on overflow.
  - On each out handshake: stat_lines+=1, stat_pad_bytes += LINE_BYTES-ibytes-cbytes.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Three instructions, in_cnst_bytes=0, in_last on the third -> one line:
  - out_ninst=3, out_cnst_base=63;
  - bytes 0..17 = instructions in order, bytes 18..63 = 8'h00.
- One instruction with in_cnst_bytes=8, in_cnst=64'h0807060504030201, in_last -> byte56=8'h01 ... byte63=8'h08, out_cnst_base=56, out_ninst=1.
- Three instructions, each with 24 constant bytes:
  - third does not fit (18+72>64), so first line emits with out_ninst=2, out_cnst_base=16;
  - third lands in the next line at bytes 0..5, constants at 40..63.
- Ten bare instructions, no in_last -> line auto-closes after the tenth (MAX_INST): out_ninst=10, bytes 60..63 = FILL_BYTE, in_ready=0 during EMIT.
- Hold out_ready=0 for 5 cycles in EMIT -> out_valid stays 1, out_line unchanged, in_ready=0; out_ready=1 -> in_ready=1 the next cycle.
- Assert rst while out_valid=1 -> out_valid=0 at once; after release, first in_last instruction produces out_ninst=1.
  - With QUPLS4_PACK_STATS_EN: stat_lines=0 after reset, 1 after that line.
